// File: rtl/fpu_sequencer_if.sv
// Command / FPU / result bundle for fpu_sequencer.
// Command in:  in_valid, in_ready, in_opA, in_opB, in_op
// FPU issue:   fpu_opA, fpu_opB, fpu_op, fpu_start
// FPU return:  fpu_result, fpu_overflow, fpu_underflow, fpu_inexact
// Result out:  out_valid, out_ready, out_result, out_flags, out_op
// slave is the sequencer's view; master is the surrounding environment's view.
interface fpu_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_opA;
    logic [15:0] in_opB;
    logic [1:0]  in_op;

    logic [15:0] fpu_opA;
    logic [15:0] fpu_opB;
    logic [1:0]  fpu_op;
    logic        fpu_start;
    logic [15:0] fpu_result;
    logic        fpu_overflow;
    logic        fpu_underflow;
    logic        fpu_inexact;

    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [2:0]  out_flags;
    logic [1:0]  out_op;

    modport slave (
        input  in_valid, in_opA, in_opB, in_op,
        output in_ready,
        output fpu_opA, fpu_opB, fpu_op, fpu_start,
        input  fpu_result, fpu_overflow, fpu_underflow, fpu_inexact,
        output out_valid, out_result, out_flags, out_op,
        input  out_ready
    );

    modport master (
        output in_valid, in_opA, in_opB, in_op,
        input  in_ready,
        input  fpu_opA, fpu_opB, fpu_op, fpu_start,
        output fpu_result, fpu_overflow, fpu_underflow, fpu_inexact,
        input  out_valid, out_result, out_flags, out_op,
        output out_ready
    );
endinterface

// File: rtl/fpu_sequencer.sv
// Queues half-precision FPU commands in a small FIFO and issues them one at a
// time to an external fixed-latency FPU, holding each result until consumed.
// Ports: clk, reset_n (async active-low), bus (fpu_sequencer_if.slave: command
// intake, FPU issue/return, result handshake), count (FIFO occupancy), busy.
module fpu_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ADD_LAT = 2,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned DIV_LAT = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    fpu_sequencer_if.slave bus,
    output logic [3:0]     count,
    output logic           busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] op_a;
        logic [15:0] op_b;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_d;
    cmd_t               mem [DEPTH];
    cmd_t               in_cmd;
    cmd_t               head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [3:0]         lat_cnt;
    logic               push_c;
    logic               pop_c;
    logic               cap_c;
    logic               done_c;

    logic [15:0]        fpu_op_a_q;
    logic [15:0]        fpu_op_b_q;
    logic [1:0]         fpu_op_q;
    logic               fpu_start_q;
    logic               out_valid_q;
    logic [15:0]        out_result_q;
    logic [2:0]         out_flags_q;
    logic [1:0]         out_op_q;

    // Execution cycles per opcode.
    function automatic logic [3:0] lat_of(input logic [1:0] op);
        logic [3:0] lat;
        unique case (op)
            2'b10:   lat = 4'(MUL_LAT);
            2'b11:   lat = 4'(DIV_LAT);
            default: lat = 4'(ADD_LAT);
        endcase
        return lat;
    endfunction

    // Intake depends only on the registered occupancy.
    assign bus.in_ready = (count != CNT_W'(DEPTH));
    assign push_c       = bus.in_valid && bus.in_ready;
    assign in_cmd       = '{op: bus.in_op, op_a: bus.in_opA, op_b: bus.in_opB};
    assign head         = mem[rd_ptr];
    assign busy         = (state != IDLE) || (count != '0);

    assign bus.fpu_opA    = fpu_op_a_q;
    assign bus.fpu_opB    = fpu_op_b_q;
    assign bus.fpu_op     = fpu_op_q;
    assign bus.fpu_start  = fpu_start_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_flags  = out_flags_q;
    assign bus.out_op     = out_op_q;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and control strobes.
    always_comb begin
        state_d = state;
        pop_c   = 1'b0;
        cap_c   = 1'b0;
        done_c  = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    pop_c   = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (lat_cnt == 4'd1) begin
                    cap_c   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    done_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= in_cmd;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Issue registers and latency counter; operands persist until the next pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fpu_op_a_q  <= '0;
            fpu_op_b_q  <= '0;
            fpu_op_q    <= '0;
            fpu_start_q <= 1'b0;
            lat_cnt     <= '0;
        end else begin
            fpu_start_q <= pop_c;
            if (pop_c) begin
                fpu_op_a_q <= head.op_a;
                fpu_op_b_q <= head.op_b;
                fpu_op_q   <= head.op;
                lat_cnt    <= lat_of(head.op);
            end else if (state == EXEC) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
        end
    end

    // Result capture and hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
            out_op_q     <= '0;
        end else begin
            if (cap_c) begin
                out_valid_q  <= 1'b1;
                out_result_q <= bus.fpu_result;
                out_flags_q  <= {bus.fpu_overflow, bus.fpu_underflow, bus.fpu_inexact};
                out_op_q     <= fpu_op_q;
            end else if (done_c) begin
                out_valid_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fpu_sequencer.sv
// Randomized and directed bench for fpu_sequencer against a transaction-level
// reference: a queue of accepted commands, one in-flight command timed by edge
// arithmetic, and an FPU stub that only presents a valid result in the last
// execution cycle.
module tb_fpu_sequencer;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned ADD_LAT = 2;
    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned DIV_LAT = 8;

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } tcmd_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] count;
    logic       busy;

    fpu_sequencer_if bus();

    fpu_sequencer #(
        .DEPTH   (DEPTH),
        .ADD_LAT (ADD_LAT),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .count   (count),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input logic [1:0] op);
        if (op == 2'b10) return int'(MUL_LAT);
        if (op == 2'b11) return int'(DIV_LAT);
        return int'(ADD_LAT);
    endfunction

    // Behavioural FPU: {overflow, underflow, inexact, result}.
    function automatic logic [18:0] fpu_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic [1:0] op);
        logic [15:0] r;
        logic        ov;
        logic        un;
        logic        ix;
        if (a == 16'h3C00 && b == 16'h4000 && op == 2'b00) r = 16'h4200;
        else r = (a ^ {b[7:0], b[15:8]}) + (16'h1111 * 16'(op));
        ov = (op == 2'b10) && a[14] && b[14];
        un = (op == 2'b11) && b[14] && !a[14];
        ix = a[0] ^ b[0];
        return {ov, un, ix, r};
    endfunction

    // FPU stub: garbage except in the final execution cycle of the command.
    int          f_el;
    int          f_cyc;
    logic        f_ready;
    logic [18:0] f_val;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)            f_el <= 0;
        else if (bus.fpu_start)  f_el <= 2;
        else if (f_el != 0)      f_el <= f_el + 1;
    end

    assign f_cyc          = bus.fpu_start ? 1 : f_el;
    assign f_ready        = (f_cyc == lat_of(bus.fpu_op));
    assign f_val          = fpu_ref(bus.fpu_opA, bus.fpu_opB, bus.fpu_op);
    assign bus.fpu_result = f_ready ? f_val[15:0] : 16'hDEAD;
    assign {bus.fpu_overflow, bus.fpu_underflow, bus.fpu_inexact} = f_ready ? f_val[18:16] : 3'b111;

    // Reference model state.
    tcmd_t q[$];
    tcmd_t cur = '0;
    tcmd_t m_cmd;
    bit    m_push   = 1'b0;
    bit    m_busy   = 1'b0;
    bit    m_hold   = 1'b0;
    bit    have_cur = 1'b0;
    int    cyc       = 0;
    int    issue_cyc = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_busy    = 1'b0;
            m_hold    = 1'b0;
            have_cur  = 1'b0;
            cyc       = 0;
            issue_cyc = 0;
        end else begin
            cyc    = cyc + 1;
            m_push = bus.in_valid && (q.size() != int'(DEPTH));
            m_cmd  = {bus.in_op, bus.in_opA, bus.in_opB};
            if (m_hold) begin
                if (bus.out_ready) begin
                    m_hold = 1'b0;
                    m_busy = 1'b0;
                end
            end else if (m_busy) begin
                if (cyc - issue_cyc == lat_of(cur.op)) m_hold = 1'b1;
            end else if (q.size() != 0) begin
                cur       = q.pop_front();
                have_cur  = 1'b1;
                m_busy    = 1'b1;
                issue_cyc = cyc;
            end
            if (m_push) q.push_back(m_cmd);
        end
    end

    // Cycle-by-cycle comparison of DUT outputs against the model.
    logic [18:0] exp_v;
    always @(negedge clk) begin
        check_eq("out_valid", 32'(bus.out_valid), 32'(m_hold));
        check_eq("in_ready", 32'(bus.in_ready), 32'(q.size() != int'(DEPTH)));
        check_eq("count", 32'(count), 32'(q.size()));
        check_eq("busy", 32'(busy), 32'(m_busy || q.size() != 0));
        check_eq("fpu_start", 32'(bus.fpu_start), 32'(m_busy && !m_hold && cyc == issue_cyc));
        check_eq("fpu_opA", 32'(bus.fpu_opA), have_cur ? 32'(cur.a) : 32'd0);
        check_eq("fpu_opB", 32'(bus.fpu_opB), have_cur ? 32'(cur.b) : 32'd0);
        check_eq("fpu_op", 32'(bus.fpu_op), have_cur ? 32'(cur.op) : 32'd0);
        if (m_hold) begin
            exp_v = fpu_ref(cur.a, cur.b, cur.op);
            check_eq("out_result", 32'(bus.out_result), 32'(exp_v[15:0]));
            check_eq("out_flags", 32'(bus.out_flags), 32'(exp_v[18:16]));
            check_eq("out_op", 32'(bus.out_op), 32'(cur.op));
        end
    end

    task automatic offer(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_opA   = a;
        bus.in_opB   = b;
    endtask

    task automatic no_offer();
        bus.in_valid = 1'b0;
    endtask

    // Counts negedges until out_valid is seen (bounded).
    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            n = n + 1;
            if (bus.out_valid) break;
        end
        if (!bus.out_valid) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic drain();
        int k;
        no_offer();
        bus.out_ready = 1'b1;
        k = 0;
        while (k < 200 && busy) begin
            @(negedge clk);
            k = k + 1;
        end
        check_eq("drain_busy", 32'(busy), 32'd0);
    endtask

    int          n;
    int          n_start;
    int          n_ov;
    logic [15:0] r0;
    logic [2:0]  f0;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'b00;
        bus.in_opA    = 16'h0;
        bus.in_opB    = 16'h0;
        bus.out_ready = 1'b0;

        // Outputs while held in reset.
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_out_result", 32'(bus.out_result), 32'd0);
        check_eq("rst_fpu_start", 32'(bus.fpu_start), 32'd0);

        // Single add offered straight out of reset.
        #2 reset_n = 1'b1;
        bus.out_ready = 1'b1;
        offer(2'b00, 16'h3C00, 16'h4000);
        @(negedge clk);
        no_offer();
        check_eq("first_push_count", 32'(count), 32'd1);
        wait_valid("add_lat", n);
        check_eq("add_latency", 32'(n), 32'(ADD_LAT + 1));
        check_eq("add_result", 32'(bus.out_result), 32'h4200);
        check_eq("add_flags", 32'(bus.out_flags), 32'd0);
        check_eq("add_op", 32'(bus.out_op), 32'd0);
        drain();

        // Multiply overflow flag.
        offer(2'b10, 16'h7800, 16'h7800);
        @(negedge clk);
        no_offer();
        wait_valid("mul_lat", n);
        check_eq("mul_latency", 32'(n), 32'(MUL_LAT + 1));
        check_eq("mul_flags", 32'(bus.out_flags), 32'b100);
        check_eq("mul_op", 32'(bus.out_op), 32'b10);
        drain();

        // Divide followed by add: order and per-opcode latency.
        offer(2'b11, 16'h1234, 16'h5678);
        @(negedge clk);
        offer(2'b00, 16'h0101, 16'h2020);
        @(negedge clk);
        no_offer();
        wait_valid("div_lat", n);
        check_eq("div_latency", 32'(n), 32'(DIV_LAT));
        check_eq("div_op", 32'(bus.out_op), 32'b11);
        wait_valid("add2_lat", n);
        check_eq("add_after_div", 32'(n), 32'(ADD_LAT + 2));
        check_eq("add2_op", 32'(bus.out_op), 32'b00);
        drain();

        // Fill with no consumer, then hold a result under back-pressure.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            offer(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
            @(negedge clk);
        end
        no_offer();
        check_eq("fill_count", 32'(count), 32'(DEPTH));
        check_eq("fill_in_ready", 32'(bus.in_ready), 32'd0);
        wait_valid("fill_first", n);
        r0 = bus.out_result;
        f0 = bus.out_flags;
        n_start = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.fpu_start) n_start = n_start + 1;
        end
        check_eq("bp_result_stable", 32'(bus.out_result), 32'(r0));
        check_eq("bp_flags_stable", 32'(bus.out_flags), 32'(f0));
        check_eq("bp_no_start", 32'(n_start), 32'd0);
        check_eq("bp_still_full", 32'(count), 32'(DEPTH));
        drain();

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 2) != 0)
                offer(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
            else
                no_offer();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        drain();

        // Reset during a divide with two commands queued.
        offer(2'b11, 16'h4444, 16'h0101);
        @(negedge clk);
        offer(2'b00, 16'h1111, 16'h2222);
        @(negedge clk);
        offer(2'b01, 16'h3333, 16'h4444);
        @(negedge clk);
        no_offer();
        n = 0;
        while (n < 20 && !bus.fpu_start) begin
            @(negedge clk);
            n = n + 1;
        end
        check_eq("rst_mid_saw_start", 32'(bus.fpu_start), 32'd1);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("mid_rst_count", 32'(count), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_fpu_op", 32'(bus.fpu_op), 32'd0);
        check_eq("mid_rst_fpu_opA", 32'(bus.fpu_opA), 32'd0);
        check_eq("mid_rst_fpu_opB", 32'(bus.fpu_opB), 32'd0);
        check_eq("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mid_rst_out_flags", 32'(bus.out_flags), 32'd0);
        check_eq("mid_rst_out_op", 32'(bus.out_op), 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        bus.out_ready = 1'b1;
        n_ov = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) n_ov = n_ov + 1;
        end
        check_eq("post_rst_no_result", 32'(n_ov), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/fpu_sequencer.md
FPU_SEQUENCER -- requirements
Module: fpu_sequencer

Interface
REQ-001 Parameter DEPTH, default 4: command FIFO entries; power of two, 2..8.
REQ-002 Parameter ADD_LAT, default 2: FPU cycles for op 00/01, range 1..15.
REQ-003 Parameter MUL_LAT, default 3: FPU cycles for op 10, range 1..15.
REQ-004 Parameter DIV_LAT, default 8: FPU cycles for op 11, range 1..15.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  command offered.
REQ-008 in_ready  output  1  FIFO can accept a command.
REQ-009 in_opA, in_opB  input  16 each  half-precision operands.
REQ-010 in_op  input  2  00 add, 01 sub, 10 mul, 11 div.
REQ-011 fpu_opA, fpu_opB  output  16 each  operands driven to FPU.
REQ-012 fpu_op  output  2  opcode driven to FPU.
REQ-013 fpu_start  output  1  one-cycle issue pulse to FPU.
REQ-014 fpu_result  input  16  FPU result.
REQ-015 fpu_overflow, fpu_underflow, fpu_inexact  input  1 each  FPU flags.
REQ-016 out_valid  output  1  result held for consumer.
REQ-017 out_ready  input  1  consumer accepts result.
REQ-018 out_result  output  16  captured result.
REQ-019 out_flags  output  3  {overflow, underflow, inexact} captured.
REQ-020 out_op  output  2  opcode of captured result.
REQ-021 count  output  4  FIFO occupancy, 0..DEPTH.
REQ-022 busy  output  1  high when state != IDLE or count != 0.

Function
REQ-023 Push occurs on a rising edge where in_valid and in_ready are both high; in_ready SHALL equal (count != DEPTH), derived from registered count only.
REQ-024 A push while full SHALL not occur; a push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-025 FIFO read/write pointers SHALL wrap modulo DEPTH; commands issue in strict arrival order.
REQ-026 FSM states: IDLE, EXEC, DONE.
REQ-027 IDLE with count != 0: pop head into issue registers (fpu_opA/opB/op), load cycle counter with LAT(op), go EXEC; IDLE with count == 0: remain.
REQ-028 fpu_start SHALL be high exactly in the first EXEC cycle of each command, low otherwise.
REQ-029 fpu_opA/opB/op SHALL hold stable from pop until the next pop; sub passes in_op 01 unchanged (FPU negates opB).
REQ-030 EXEC SHALL last exactly LAT(op) cycles; on the edge ending the last EXEC cycle, fpu_result and flags are captured into out_result/out_flags, out_op set, state goes DONE.
REQ-031 DONE: out_valid high; out_result/out_flags/out_op stable; on edge with out_ready high go IDLE, out_valid low next cycle.
REQ-032 out_valid SHALL be high only in DONE; out_ready outside DONE is ignored.
REQ-033 Latency: a command accepted at edge E into an empty, idle block raises out_valid after edge E+1+LAT(op).
REQ-034 Throughput: one command per LAT(op)+2 cycles minimum with out_ready held high (one IDLE bubble per command).
REQ-035 Pushes SHALL continue during EXEC/DONE while not full; back-pressure on out_ready stalls issue but not intake.

Reset
REQ-036 reset_n low SHALL asynchronously force state IDLE, count 0, pointers 0, fpu_start 0, out_valid 0, out_result 0, out_flags 0, out_op 0, fpu_opA/opB/op 0, counter 0.
REQ-037 Reset mid-EXEC or mid-DONE SHALL discard in-flight and queued commands; no result emerges after release.
REQ-038 First push accepted on first rising edge after reset_n deasserts (in_ready high, count 0).

Verification
REQ-039 Single add: push opA 0x3C00, opB 0x4000, op 00 at edge E, FPU model returns 0x4200 -> fpu_start high one cycle after E+1, out_valid after edge E+3, out_result 0x4200, out_flags 000.
REQ-040 Fill: push 5 commands back-to-back with out_ready 0, DEPTH 4 -> count reaches 4 after first pop refills, in_ready low when count 4, 5th held until pop; results emerge in push order.
REQ-041 Mixed latency: push div then add -> div result (out_op 11) after 9 cycles, add (out_op 00) strictly after; fpu_op held 11 for all 8 EXEC cycles.
REQ-042 Back-pressure: out_ready low 10 cycles in DONE -> out_result/out_flags stable, no fpu_start pulses, FIFO still accepts pushes.
REQ-043 Flags: FPU model asserts overflow on mul -> out_flags 100, out_op 10.
REQ-044 Reset mid-EXEC of div with 2 queued -> all outputs 0 immediately, count 0, no out_valid after release.
